imem_fetch_server: RTL and testbench
====================================

// Module: imem_fetch_server
// PURPOSE
//  Dual-word instruction memory server. It responds to the core's fetch
//  requests (imem_ren/imem_addr0/imem_addr1 -> imem_valid/rdata/pc) with a
//  fixed, parameterised latency, and provides a synchronous program-load write
//  port so benches and boot logic load code without hierarchical pokes. It is
//  the responder end of the fetch interface and sits beside ooo_core_top as
//  its imem.
// PARAMETERS
//  DEPTH      256           words of storage (power of 2, >=4)
//  LATENCY    2             request-to-response cycles (1..4)
//  NOP_WORD   32'hFC000000  word returned for out-of-range/misaligned fetches
// PORTS
//  clk          in   1   clock
//  reset        in   1   async active-high reset
//  imem_ren     in   1   fetch request strobe
//  imem_addr0   in   32  byte address, lane 0
//  imem_addr1   in   32  byte address, lane 1 (normally addr0+4)
//  flush        in   1   squash every in-flight response
//  imem_valid   out  1   response valid (single-cycle pulse per request)
//  imem_rdata0  out  32  instruction at imem_pc0
//  imem_rdata1  out  32  instruction at imem_pc1
//  imem_pc0     out  32  echo of the addr0 that produced rdata0
//  imem_pc1     out  32  echo of the addr1 that produced rdata1
//  imem_err     out  2   per-lane fault: [i]=1 if addr_i misaligned or >=DEPTH*4
//  load_we      in   1   program-load write strobe
//  load_addr    in   $clog2(DEPTH)  word index to write
//  load_wdata   in   32  word to write
//  load_count   out  16  number of load writes accepted since reset (saturates)
// BEHAVIOUR
//  - Reset: imem_valid=0, imem_err=0, rdata/pc outputs=0, load_count=0, all
//    pipeline valid bits cleared. Memory contents are NOT reset; they persist
//    across reset, so a program loaded before reset survives it.
//  - Request accepted every cycle imem_ren=1. No backpressure (no ready out).
//    A request in cycle T produces imem_valid=1 in cycle T+LATENCY, with
//    rdata/pc/err captured from that request. Back-to-back requests stream
//    with one response per cycle and preserve order.
//  - Pipeline: LATENCY stages of {valid, addr0, addr1, data0, data1, err}.
//    Memory is read in stage 1. Later stages only shift.
//  - Lane independence: each lane is decoded separately. Word index = addr[..:2].
//    If addr[1:0]!=0 or index>=DEPTH: data=NOP_WORD and err[i]=1. The other
//    lane is unaffected.
//  - Write port: when load_we=1, mem[load_addr]<=load_wdata at the clock edge.
//    load_count increments and saturates at 16'hFFFF.
//  - Same-cycle write and read of the same word: the read returns the NEW data
//    (write-first bypass, per lane).
//  - Flush: all stages' valid bits clear on the flush edge, so no response
//    from a pre-flush request ever appears. A request presented in the same
//    cycle as flush is accepted and returns normally at T+LATENCY.
//  - When imem_valid=0, rdata/pc/err hold their last values. The consumer
//    qualifies them with imem_valid.
//  - Reset asserted mid-stream: all in-flight responses are dropped
//    immediately. Outputs go to their reset values asynchronously.
// TESTING
//  1 Load mem[0..3]={0x2021000A,0x20420005,0x00611020,0x00811022}, then
//    ren addr0=0,addr1=4 at T -> valid at T+2 only, rdata0=0x2021000A,
//    rdata1=0x20420005, pc0=0, pc1=4, err=0; load_count=4.
//  2 Stream ren for 4 cycles with addr0=0,8,16,24 -> 4 consecutive valid
//    pulses, in order, pc0=0,8,16,24.
//  3 ren at T and T+1, flush at T+1 -> no valid at T+2; valid at T+3 carrying
//    the T+1 request.
//  4 addr0=0x3FC (DEPTH=256), addr1=0x400 -> rdata1=0xFC000000, err=2'b10;
//    addr0=0x2 -> err[0]=1, rdata0=NOP_WORD.
//  5 load_we mem[5]=0xDEADBEEF same cycle as ren addr0=0x14 -> rdata0=0xDEADBEEF.
//  6 reset pulse with 2 requests in flight -> no valid after release;
//    previously loaded mem[0] still reads 0x2021000A; load_count=0.

Source files
------------

// File: rtl/imem_fetch_server.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_server
//  Purpose  : Dual-word instruction memory server with a fixed response
//             latency, per-lane fault decode, flush and a program-load port.
//  Revision : 1.0  initial release
// ============================================================================
module imem_fetch_server #(
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = 32'hFC000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     imem_ren,
    input  logic [31:0]              imem_addr0,
    input  logic [31:0]              imem_addr1,
    input  logic                     flush,
    output logic                     imem_valid,
    output logic [31:0]              imem_rdata0,
    output logic [31:0]              imem_rdata1,
    output logic [31:0]              imem_pc0,
    output logic [31:0]              imem_pc1,
    output logic [1:0]               imem_err,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_wdata,
    output logic [15:0]              load_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic        valid;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] data0;
        logic [31:0] data1;
        logic [1:0]  err;
    } stage_t;

    logic [31:0]         r_mem [DEPTH];
    stage_t              r_pipe [LATENCY];
    logic [15:0]         r_load_count;

    logic [c_ADDR_W-1:0] w_idx0;
    logic [c_ADDR_W-1:0] w_idx1;
    logic                w_err0;
    logic                w_err1;
    logic [31:0]         w_data0;
    logic [31:0]         w_data1;

    // Lane decode: each lane faults on its own when misaligned or beyond the
    // array; a load to the same word in this cycle is forwarded (write-first).
    assign w_idx0  = imem_addr0[c_ADDR_W+1:2];
    assign w_idx1  = imem_addr1[c_ADDR_W+1:2];
    assign w_err0  = (imem_addr0[1:0] != 2'b00) || (imem_addr0[31:c_ADDR_W+2] != '0);
    assign w_err1  = (imem_addr1[1:0] != 2'b00) || (imem_addr1[31:c_ADDR_W+2] != '0);
    assign w_data0 = w_err0 ? NOP_WORD :
                     (load_we && (load_addr == w_idx0)) ? load_wdata : r_mem[w_idx0];
    assign w_data1 = w_err1 ? NOP_WORD :
                     (load_we && (load_addr == w_idx1)) ? load_wdata : r_mem[w_idx1];

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_addr] <= load_wdata;
        end
    end

    // Accepted-load counter, saturating at all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_count <= 16'd0;
        end else if (load_we && (r_load_count != 16'hFFFF)) begin
            r_load_count <= r_load_count + 16'd1;
        end
    end

    // Response pipeline: stage 0 captures the read, later stages only shift.
    // Payload moves only with a live entry so outputs hold between pulses.
    // Flush kills entries already in flight but never the incoming request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            if (imem_ren) begin
                r_pipe[0] <= '{valid: 1'b1, addr0: imem_addr0, addr1: imem_addr1,
                               data0: w_data0, data1: w_data1,
                               err: {w_err1, w_err0}};
            end else begin
                r_pipe[0].valid <= 1'b0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (r_pipe[i-1].valid && !flush) begin
                    r_pipe[i] <= r_pipe[i-1];
                end else begin
                    r_pipe[i].valid <= 1'b0;
                end
            end
        end
    end

    assign imem_valid  = r_pipe[LATENCY-1].valid;
    assign imem_rdata0 = r_pipe[LATENCY-1].data0;
    assign imem_rdata1 = r_pipe[LATENCY-1].data1;
    assign imem_pc0    = r_pipe[LATENCY-1].addr0;
    assign imem_pc1    = r_pipe[LATENCY-1].addr1;
    assign imem_err    = r_pipe[LATENCY-1].err;
    assign load_count  = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_fetch_server
//  Purpose  : Scoreboard bench for imem_fetch_server (directed vectors).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_fetch_server;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam int          AW    = 8;
    localparam logic [31:0] NOP   = 32'hFC000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_ren;
    logic [31:0]   imem_addr0;
    logic [31:0]   imem_addr1;
    logic          flush;
    logic          imem_valid;
    logic [31:0]   imem_rdata0;
    logic [31:0]   imem_rdata1;
    logic [31:0]   imem_pc0;
    logic [31:0]   imem_pc1;
    logic [1:0]    imem_err;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_wdata;
    logic [15:0]   load_count;

    imem_fetch_server #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .imem_ren(imem_ren),
        .imem_addr0(imem_addr0), .imem_addr1(imem_addr1), .flush(flush),
        .imem_valid(imem_valid), .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
        .imem_pc0(imem_pc0), .imem_pc1(imem_pc1), .imem_err(imem_err),
        .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  e;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prog [8] = '{32'h2021000A, 32'h20420005, 32'h00611020, 32'h00811022,
                              32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (imem_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL resp: unexpected valid at cycle %0d (pc0=%h pc1=%h), none required",
                         cyc, imem_pc0, imem_pc1);
            end else begin
                cur = q.pop_front();
                if (cur.cyc != cyc || imem_rdata0 !== cur.d0 || imem_rdata1 !== cur.d1 ||
                    imem_pc0 !== cur.p0 || imem_pc1 !== cur.p1 || imem_err !== cur.e) begin
                    n_bad++;
                    $display("FAIL resp: got cyc=%0d d0=%h d1=%h pc0=%h pc1=%h err=%b, want cyc=%0d d0=%h d1=%h pc0=%h pc1=%h err=%b",
                             cyc, imem_rdata0, imem_rdata1, imem_pc0, imem_pc1, imem_err,
                             cur.cyc, cur.d0, cur.d1, cur.p0, cur.p1, cur.e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic drive(input logic ren, input logic [31:0] a0, input logic [31:0] a1,
                         input logic fl, input logic we, input logic [AW-1:0] la,
                         input logic [31:0] wd);
        @(posedge clk);
        #1;
        imem_ren   = ren;
        imem_addr0 = a0;
        imem_addr1 = a1;
        flush      = fl;
        load_we    = we;
        load_addr  = la;
        load_wdata = wd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    endtask

    task automatic load(input logic [AW-1:0] la, input logic [31:0] wd);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, la, wd);
    endtask

    // Call right after drive(): the request was set up in the current cycle.
    task automatic expect_resp(input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic [1:0] e);
        exp_t x;
        x.cyc = cyc + LAT; x.d0 = d0; x.d1 = d1; x.p0 = p0; x.p1 = p1; x.e = e;
        q.push_back(x);
    endtask

    initial begin
        reset = 1'b1; imem_ren = 1'b0; imem_addr0 = '0; imem_addr1 = '0;
        flush = 1'b0; load_we = 1'b0; load_addr = '0; load_wdata = '0;
        #2;
        check("rst_valid", {31'd0, imem_valid}, 32'd0);
        check("rst_err",   {30'd0, imem_err}, 32'd0);
        check("rst_rdata0", imem_rdata0, 32'd0);
        check("rst_pc1",   imem_pc1, 32'd0);
        check("rst_count", {16'd0, load_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic load then fetch
        for (int k = 0; k < 4; k++) load(AW'(k), prog[k]);
        drive(1'b1, 32'h0, 32'h4, 1'b0, 1'b0, '0, 32'd0);
        expect_resp(prog[0], prog[1], 32'h0, 32'h4, 2'b00);
        check("count_4", {16'd0, load_count}, 32'd4);
        idle(3);

        // Streaming, in order
        for (int k = 4; k < 8; k++) load(AW'(k), prog[k]);
        load(8'hFF, 32'h0BADF00D);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(8 * k), 32'(8 * k + 4), 1'b0, 1'b0, '0, 32'd0);
            expect_resp(prog[2*k], prog[2*k+1], 32'(8 * k), 32'(8 * k + 4), 2'b00);
        end
        idle(3);

        // Flush squashes the older request, keeps the same-cycle one
        drive(1'b1, 32'h0, 32'h4, 1'b0, 1'b0, '0, 32'd0);
        drive(1'b1, 32'h8, 32'hC, 1'b1, 1'b0, '0, 32'd0);
        expect_resp(prog[2], prog[3], 32'h8, 32'hC, 2'b00);
        idle(3);

        // Out-of-range and misaligned lanes
        drive(1'b1, 32'h3FC, 32'h400, 1'b0, 1'b0, '0, 32'd0);
        expect_resp(32'h0BADF00D, NOP, 32'h3FC, 32'h400, 2'b10);
        drive(1'b1, 32'h2, 32'h4, 1'b0, 1'b0, '0, 32'd0);
        expect_resp(NOP, prog[1], 32'h2, 32'h4, 2'b01);
        idle(3);

        // Write-first bypass, then plain read-back of the new word
        drive(1'b1, 32'h14, 32'h0, 1'b0, 1'b1, 8'd5, 32'hDEADBEEF);
        expect_resp(32'hDEADBEEF, prog[0], 32'h14, 32'h0, 2'b00);
        idle(1);
        check("count_10", {16'd0, load_count}, 32'd10);
        drive(1'b1, 32'h10, 32'h14, 1'b0, 1'b0, '0, 32'd0);
        expect_resp(prog[4], 32'hDEADBEEF, 32'h10, 32'h14, 2'b00);
        idle(3);

        // Reset with two requests in flight
        drive(1'b1, 32'h0, 32'h4, 1'b0, 1'b0, '0, 32'd0);
        drive(1'b1, 32'h8, 32'hC, 1'b0, 1'b0, '0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_ren = 1'b0;
        #1;
        check("async_valid", {31'd0, imem_valid}, 32'd0);
        check("async_pc0",   imem_pc0, 32'd0);
        check("async_rdata1", imem_rdata1, 32'd0);
        check("async_count", {16'd0, load_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(4);
        drive(1'b1, 32'h0, 32'h4, 1'b0, 1'b0, '0, 32'd0);
        expect_resp(prog[0], prog[1], 32'h0, 32'h4, 2'b00);
        check("post_rst_count", {16'd0, load_count}, 32'd0);
        idle(4);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
